// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the main memory
package mem_pkg;
    typedef logic [31:0] word_t;
    typedef logic [7:0]  byte_t;
    localparam word_t       DEFAULT_BASE_ADDR = 32'h0100_0000;
    localparam int unsigned DEFAULT_DEPTH     = 1048576;
endpackage

// File: rtl/memory.sv
// memory: byte-addressable little-endian main memory, 32-bit synchronous write / combinational read
module memory
  import mem_pkg::*;
#(
  parameter int unsigned       AWIDTH    = 32,
  parameter int unsigned       DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned       DEPTH     = DEFAULT_DEPTH,
  parameter string             MEM_FILE  = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              read_en_i,
  input  logic              write_en_i,
  output logic [DWIDTH-1:0] data_o
);
  localparam int unsigned IW = $clog2(DEPTH);
  byte_t main_memory [0:DEPTH-1] = '{default: '0};
  function automatic logic in_range(input logic [AWIDTH-1:0] a);
    logic [AWIDTH-1:0] off;
    off = a - BASE_ADDR;
    return a >= BASE_ADDR && off <= AWIDTH'(DEPTH - 4);
  endfunction
  function automatic logic [IW-1:0] offset(input logic [AWIDTH-1:0] a);
    return IW'(a - BASE_ADDR);
  endfunction
  logic          hit_d;
  logic [IW-1:0] idx_d;
  always_comb begin
    hit_d = in_range(addr_i);
    idx_d = offset(addr_i);
  end
  assign data_o = (rst && read_en_i && hit_d) ?
    {main_memory[idx_d + IW'(3)], main_memory[idx_d + IW'(2)],
     main_memory[idx_d + IW'(1)], main_memory[idx_d]} : '0;
  always_ff @(posedge clk) begin
    if (rst && write_en_i && hit_d)
      for (int k = 0; k < 4; k++)
        main_memory[idx_d + IW'(k)] <= data_i[8*k +: 8];
  end
endmodule

// File: tb/tb_memory.sv
// tb_memory: directed and random checks of memory against a sparse byte-level reference model
module tb_memory;
    import mem_pkg::*;

    localparam longint unsigned BASE  = 64'h0100_0000;
    localparam longint unsigned DEPTH = 64'd1048576;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        read_en_i  = 1'b0;
    logic        write_en_i = 1'b0;
    logic [31:0] addr_i     = '0;
    logic [31:0] data_i     = '0;
    logic [31:0] data_o;
    int          n_checks   = 0;
    int          n_fails    = 0;
    byte_t       ref_mem [longint unsigned];

    memory dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i),
        .read_en_i(read_en_i), .write_en_i(write_en_i), .data_o(data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit fits(input logic [31:0] a);
        return 64'(a) >= BASE && 64'(a) + 4 <= BASE + DEPTH;
    endfunction

    function automatic byte_t ref_byte(input longint unsigned off);
        return ref_mem.exists(off) ? ref_mem[off] : 8'h00;
    endfunction

    function automatic word_t ref_word(input longint unsigned off);
        return {ref_byte(off + 3), ref_byte(off + 2), ref_byte(off + 1), ref_byte(off)};
    endfunction

    function automatic word_t dut_word(input longint unsigned off);
        return {dut.main_memory[20'(off + 3)], dut.main_memory[20'(off + 2)],
                dut.main_memory[20'(off + 1)], dut.main_memory[20'(off)]};
    endfunction

    function automatic word_t exp_read();
        return (rst && read_en_i && fits(addr_i)) ? ref_word(64'(addr_i) - BASE) : '0;
    endfunction

    task automatic drive(input logic r, input logic re, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rst = r; read_en_i = re; write_en_i = we; addr_i = a; data_i = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst && write_en_i && fits(addr_i))
            for (int k = 0; k < 4; k++)
                ref_mem[64'(addr_i) - BASE + 64'(k)] = data_i[8*k +: 8];
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b1, 1'b1, 32'h0100_0000, 32'h1234_5678);
        tick();
        tick();
        check("reset_blocks_write", dut_word(0), 32'h0);
        check("reset_data_o", data_o, 32'h0);

        drive(1'b1, 1'b0, 1'b1, 32'h0100_0004, 32'hDEAD_BEEF);
        tick();
        check("write1", dut_word(4), 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 1'b1, 32'h0100_0020, 32'hCAFE_BABE);
        tick();
        check("write2", dut_word(32), 32'hCAFE_BABE);
        check("write2_keeps_write1", dut_word(4), 32'hDEAD_BEEF);

        drive(1'b1, 1'b1, 1'b0, 32'h0100_0004, 32'h0);
        check("read_same_cycle", data_o, 32'hDEAD_BEEF);
        tick();
        check("read_at_edge", data_o, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 1'b0, 32'h0100_0004, 32'h0);
        check("read_disabled", data_o, 32'h0);

        drive(1'b1, 1'b1, 1'b1, 32'h0100_0004, 32'h0BAD_F00D);
        check("rw_before_edge", data_o, 32'hDEAD_BEEF);
        tick();
        check("rw_after_edge", data_o, 32'h0BAD_F00D);

        drive(1'b1, 1'b0, 1'b1, 32'h0100_0001, 32'hA1B2_C3D4);
        tick();
        check("misaligned_write", dut_word(1), 32'hA1B2_C3D4);
        check("misaligned_neighbour", dut_word(4), 32'h0BAD_F0A1);

        drive(1'b1, 1'b0, 1'b1, 32'h00FF_FFFC, 32'h5555_5555);
        tick();
        check("below_base_dropped", dut_word(0), 32'hB2C3_D400);
        drive(1'b1, 1'b0, 1'b1, 32'h00FF_FFFE, 32'h6666_6666);
        tick();
        check("straddle_base_dropped", dut_word(0), 32'hB2C3_D400);

        drive(1'b1, 1'b0, 1'b1, 32'h010F_FFFC, 32'h1122_3344);
        tick();
        check("last_word_write", dut_word(DEPTH - 4), 32'h1122_3344);
        drive(1'b1, 1'b1, 1'b0, 32'h010F_FFFC, 32'h0);
        check("last_word_read", data_o, 32'h1122_3344);
        drive(1'b1, 1'b1, 1'b0, 32'h010F_FFFE, 32'h0);
        check("read_past_end", data_o, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h010F_FFFD, 32'h7777_7777);
        tick();
        check("write_past_end_dropped", dut_word(DEPTH - 4), 32'h1122_3344);

        drive(1'b0, 1'b1, 1'b1, 32'h0100_0020, 32'h9999_9999);
        check("mid_reset_data_o", data_o, 32'h0);
        tick();
        check("mid_reset_no_write", dut_word(32), 32'hCAFE_BABE);
        drive(1'b1, 1'b1, 1'b0, 32'h0100_0020, 32'h0);
        check("retained_after_reset", data_o, 32'hCAFE_BABE);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 5) == 0) ? 32'h010F_FFF0 + 32'($urandom_range(0, 19))
                                            : 32'h00FF_FFFC + 32'($urandom_range(0, 75));
            drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), a, $urandom);
            check("rand_read", data_o, exp_read());
            tick();
        end
        for (int o = 0; o <= 72; o += 4)
            check("sweep_low", dut_word(64'(o)), ref_word(64'(o)));
        for (int o = 16; o >= 4; o -= 4)
            check("sweep_high", dut_word(DEPTH - 64'(o)), ref_word(DEPTH - 64'(o)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
